// File: rtl/dmem_arb_pkg.sv
// Shared requester ids, response-state type and address range check for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DMA = 1;

    typedef enum logic {
        RSP_IDLE,
        RSP_PEND
    } rsp_state_t;

    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two packed request ports and a shared response.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way grant selection: a lone requester always wins; on contention the pointer or fixed
// priority decides.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       fixed_pri,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant[REQ_CPU] = 1'b1;
            2'b10:   grant[REQ_DMA] = 1'b1;
            // rr_last names the requester served last, so the other one goes next
            2'b11: begin
                if (fixed_pri || rr_last) grant[REQ_CPU] = 1'b1;
                else                      grant[REQ_DMA] = 1'b1;
            end
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-stage response sequencer in front of the single-ported data memory.
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_conflict
`endif
);
    logic [1:0]        grant;
    logic [1:0]        gnt;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rsp_state_t        rsp_state_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rr_last_q;

    dmem_rr_pick u_pick (
        .valid     (bus.req_valid),
        .rr_last   (rr_last_q),
        .fixed_pri (FIXED_PRI),
        .grant     (grant)
    );

    // Reset also blocks new grants so nothing reaches the memory while rst is low.
    assign gnt    = rst ? grant : 2'b00;
    assign accept = |gnt;
    assign sel    = gnt[REQ_DMA];

    always_comb begin
        sel_we    = bus.req_we[REQ_CPU];
        sel_addr  = bus.req_addr[0 +: ADDR_W];
        sel_wdata = bus.req_wdata[0 +: DATA_W];
        if (sel) begin
            sel_we    = bus.req_we[REQ_DMA];
            sel_addr  = bus.req_addr[ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[DATA_W +: DATA_W];
        end
        sel_in_range = addr_in_range(64'(sel_addr), 64'(DEPTH));
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (accept) begin
            mem_we = sel_we & sel_in_range;
            mem_a  = sel_addr;
            mem_wd = sel_wdata;
        end
    end

    assign bus.req_ready = gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_state_q <= RSP_IDLE;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rr_last_q   <= 1'b1;
        end else if (accept) begin
            rsp_state_q <= RSP_PEND;
            rsp_id_q    <= sel;
            rsp_rdata_q <= (!sel_we && sel_in_range) ? mem_rd : '0;
            rsp_err_q   <= !sel_in_range;
            rr_last_q   <= sel;
        end else begin
            rsp_state_q <= RSP_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end
    end

    always_comb begin
        bus.rsp_valid = 2'b00;
        if (rsp_state_q == RSP_PEND) bus.rsp_valid[rsp_id_q] = 1'b1;
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0_q;
    logic [31:0] perf_grant1_q;
    logic [31:0] perf_conflict_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (gnt[REQ_CPU] && (perf_grant0_q != '1)) perf_grant0_q <= perf_grant0_q + 32'd1;
            if (gnt[REQ_DMA] && (perf_grant1_q != '1)) perf_grant1_q <= perf_grant1_q + 32'd1;
            if ((&bus.req_valid) && (perf_conflict_q != '1)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences, random traffic
// against a reference model. Honours DMEM_ARB_PERF_EN when defined.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        mem_we,  mem_we2;
    logic [31:0] mem_a,   mem_a2;
    logic [31:0] mem_wd,  mem_wd2;
    logic [31:0] mem_rd,  mem_rd2;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
    logic [31:0] perf2_grant0, perf2_grant1, perf2_conflict;
`endif

    int total;
    int bad;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .FIXED_PRI(1'b0)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .FIXED_PRI(1'b1)) u_dut_fixed (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus2),
        .mem_we (mem_we2),
        .mem_a  (mem_a2),
        .mem_wd (mem_wd2),
        .mem_rd (mem_rd2)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_grant0   (perf2_grant0),
        .perf_grant1   (perf2_grant1),
        .perf_conflict (perf2_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Memory stand-in: synchronous write, combinational read.
    logic [31:0] dmem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) dmem[i] = i;
        dmem[0] = 32'd3;
        dmem[1] = 32'd7;
        dmem[7] = 32'd1000;
        forever begin
            @(posedge clk);
            if (mem_we) dmem[mem_a[9:0]] <= mem_wd;
        end
    end
    assign mem_rd  = dmem[mem_a[9:0]];
    assign mem_rd2 = mem_a2 + 32'd100;

    // Reference model: abstract memory contents plus the promised next-cycle response.
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_last;
    logic [1:0]  m_pend_oh;
    logic [31:0] m_pend_rd;
    logic        m_pend_err;
    int          m_g0, m_g1, m_cf;

    task automatic model_reset();
        m_last     = 1;
        m_pend_oh  = 2'b00;
        m_pend_rd  = 32'd0;
        m_pend_err = 1'b0;
        m_g0 = 0;
        m_g1 = 0;
        m_cf = 0;
    endtask

    // Winner: the lone requester, or on contention the one not served last.
    function automatic logic [1:0] exp_grant(input logic [1:0] v);
        if (v == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drives one cycle of requests, checks at negedge, advances the model.
    task automatic run_cycle(input logic [1:0] v, input logic [1:0] we,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input bit tab, input logic [1:0] t_ready, input logic [1:0] t_rv,
                             input logic [31:0] t_rd, input logic t_err);
        logic [1:0]  eg;
        int          g;
        logic [31:0] a;
        logic [31:0] d;
        logic        inr;
        logic        ewe;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        eg  = exp_grant(v);
        g   = eg[1] ? 1 : 0;
        a   = g ? a1 : a0;
        d   = g ? d1 : d0;
        inr = (a < DEPTH);
        ewe = (eg != 2'b00) && we[g] && inr;
        @(negedge clk);
        chk("req_ready", bus.req_ready, eg);
        chk("rsp_valid", bus.rsp_valid, m_pend_oh);
        chk("rsp_rdata", bus.rsp_rdata, m_pend_rd);
        chk("rsp_err", bus.rsp_err, m_pend_err);
        chk("mem_we", mem_we, ewe);
        chk("mem_a", mem_a, (eg != 2'b00) ? a : 32'd0);
        if (ewe) chk("mem_wd", mem_wd, d);
        if (tab) begin
            chk("tab_ready", bus.req_ready, t_ready);
            chk("tab_rsp_valid", bus.rsp_valid, t_rv);
            chk("tab_rdata", bus.rsp_rdata, t_rd);
            chk("tab_err", bus.rsp_err, t_err);
        end
        @(posedge clk);
        #1;
        if (v == 2'b11) m_cf++;
        if (eg != 2'b00) begin
            m_pend_oh  = eg;
            m_pend_rd  = (we[g] || !inr) ? 32'd0 : ref_mem[a[9:0]];
            m_pend_err = !inr;
            m_last     = g;
            if (g == 0) m_g0++;
            else        m_g1++;
            if (we[g] && inr) ref_mem[a[9:0]] = d;
        end else begin
            m_pend_oh  = 2'b00;
            m_pend_rd  = 32'd0;
            m_pend_err = 1'b0;
        end
    endtask

    task automatic idle();
        run_cycle(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0);
    endtask

    // Asserts reset with both requesters valid, checks the quiet outputs, then releases.
    task automatic do_reset();
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr  = {32'd9, 32'd8};
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd1024 + 32'($urandom_range(0, 3000));
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 31));
    endfunction

    typedef struct {
        bit          rst_first;
        logic [1:0]  v;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic [1:0]  rv;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tab [14];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = i;
        ref_mem[0] = 32'd3;
        ref_mem[1] = 32'd7;
        ref_mem[7] = 32'd1000;
        model_reset();

        // Lone CPU read, then alternating contention, write-then-read, out-of-range accesses.
        tab[0]  = '{1'b0, 2'b01, 2'b00, 32'd7,    32'd0,  32'd0, 32'd0,  2'b01, 2'b00, 32'd0,    1'b0};
        tab[1]  = '{1'b0, 2'b00, 2'b00, 32'd0,    32'd0,  32'd0, 32'd0,  2'b00, 2'b01, 32'd1000, 1'b0};
        tab[2]  = '{1'b1, 2'b11, 2'b00, 32'd0,    32'd1,  32'd0, 32'd0,  2'b01, 2'b00, 32'd0,    1'b0};
        tab[3]  = '{1'b0, 2'b11, 2'b00, 32'd0,    32'd1,  32'd0, 32'd0,  2'b10, 2'b01, 32'd3,    1'b0};
        tab[4]  = '{1'b0, 2'b11, 2'b00, 32'd0,    32'd1,  32'd0, 32'd0,  2'b01, 2'b10, 32'd7,    1'b0};
        tab[5]  = '{1'b0, 2'b11, 2'b00, 32'd0,    32'd1,  32'd0, 32'd0,  2'b10, 2'b01, 32'd3,    1'b0};
        tab[6]  = '{1'b0, 2'b00, 2'b00, 32'd0,    32'd0,  32'd0, 32'd0,  2'b00, 2'b10, 32'd7,    1'b0};
        tab[7]  = '{1'b0, 2'b10, 2'b10, 32'd0,    32'd20, 32'd0, 32'd55, 2'b10, 2'b00, 32'd0,    1'b0};
        tab[8]  = '{1'b0, 2'b01, 2'b00, 32'd20,   32'd0,  32'd0, 32'd0,  2'b01, 2'b10, 32'd0,    1'b0};
        tab[9]  = '{1'b0, 2'b00, 2'b00, 32'd0,    32'd0,  32'd0, 32'd0,  2'b00, 2'b01, 32'd55,   1'b0};
        tab[10] = '{1'b0, 2'b01, 2'b00, 32'd1024, 32'd0,  32'd0, 32'd0,  2'b01, 2'b00, 32'd0,    1'b0};
        tab[11] = '{1'b0, 2'b01, 2'b01, 32'd2000, 32'd0,  32'd9, 32'd0,  2'b01, 2'b01, 32'd0,    1'b1};
        tab[12] = '{1'b0, 2'b01, 2'b00, 32'd2,    32'd0,  32'd0, 32'd0,  2'b01, 2'b01, 32'd0,    1'b1};
        tab[13] = '{1'b0, 2'b00, 2'b00, 32'd0,    32'd0,  32'd0, 32'd0,  2'b00, 2'b01, 32'd2,    1'b0};

        rst            = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_we     = 2'b00;
        bus.req_addr   = {32'd6, 32'd5};
        bus.req_wdata  = '0;
        bus2.req_valid = 2'b11;
        bus2.req_we    = 2'b00;
        bus2.req_addr  = {32'd6, 32'd5};
        bus2.req_wdata = '0;
        #1 rst = 1'b0;

        @(negedge clk);
        chk("init_ready", bus.req_ready, 2'b00);
        chk("init_ready2", bus2.req_ready, 2'b00);
        chk("init_rsp_valid", bus.rsp_valid, 2'b00);
        chk("init_rdata", bus.rsp_rdata, 32'd0);
        chk("init_err", bus.rsp_err, 1'b0);
        chk("init_mem_we", mem_we, 1'b0);
        chk("init_mem_a", mem_a, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("init_perf_grant0", perf_grant0, 32'd0);
        chk("init_perf_conflict", perf_conflict, 32'd0);
`endif
        @(posedge clk);
        #1;
        bus.req_valid  = 2'b00;
        bus2.req_valid = 2'b00;
        rst = 1'b1;
        model_reset();

        foreach (tab[i]) begin
            if (tab[i].rst_first) do_reset();
            run_cycle(tab[i].v, tab[i].we, tab[i].a0, tab[i].a1, tab[i].d0, tab[i].d1,
                      1'b1, tab[i].ready, tab[i].rv, tab[i].rd, tab[i].err);
        end
        idle();

        // Fixed priority: the CPU wins every contended cycle, back-to-back pulses to it.
        bus2.req_valid = 2'b11;
        bus2.req_addr  = {32'd6, 32'd5};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fixed_ready", bus2.req_ready, 2'b01);
            chk("fixed_rsp_valid", bus2.rsp_valid, (k == 0) ? 2'b00 : 2'b01);
            if (k > 0) chk("fixed_rdata", bus2.rsp_rdata, 32'd105);
            @(posedge clk);
            #1;
        end
        bus2.req_valid = 2'b00;
        @(negedge clk);
        chk("fixed_last_pulse", bus2.rsp_valid, 2'b01);
        chk("fixed_last_rdata", bus2.rsp_rdata, 32'd105);
        @(posedge clk);
        #1;
        idle();

        // Reset in the response cycle of an accepted read drops the pulse immediately.
        run_cycle(2'b01, 2'b00, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0);
        chk("pre_rst_pulse", bus.rsp_valid, m_pend_oh);
        chk("pre_rst_rdata", bus.rsp_rdata, m_pend_rd);
        bus.req_valid = 2'b01;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("midrst_rdata", bus.rsp_rdata, 32'd0);
        chk("midrst_err", bus.rsp_err, 1'b0);
        chk("midrst_ready", bus.req_ready, 2'b00);
        chk("midrst_mem_a", mem_a, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("midrst_perf_grant0", perf_grant0, 32'd0);
        chk("midrst_perf_grant1", perf_grant1, 32'd0);
        chk("midrst_perf_conflict", perf_conflict, 32'd0);
`endif
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        model_reset();
        idle();
        idle();

        // Random traffic, including addr/we/wdata changing while a requester waits.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] rv;
            logic [1:0] rwe;
            rv  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            rwe = 2'($urandom_range(0, 3));
            run_cycle(rv, rwe, rand_addr(), rand_addr(), $urandom, $urandom,
                      1'b0, 2'b00, 2'b00, 32'd0, 1'b0);
        end
        idle();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_grant0", perf_grant0, 32'(m_g0));
        chk("perf_grant1", perf_grant1, 32'(m_g1));
        chk("perf_conflict", perf_conflict, 32'(m_cf));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
